// File: rtl/tri_fu_mul_bthacc.sv
// tri_fu_mul_bthacc: digit-serial radix-4 Booth re-encoder.
// Rebuilds the two's-complement operand from its Booth select lines
// (s_neg, s_x, s_x2). Digits arrive most-significant first, one per handshake.
//
// Ports:
//   nclk, rst_b        clock (rising edge), asynchronous active-low reset
//   start              begin a new operand (honoured only in IDLE)
//   dig_val / dig_rdy  digit handshake; transfer when both are high
//   s_neg, s_x, s_x2   Booth digit select lines
//   res_val / res_rdy  result handshake
//   res [0:WIDTH-1]    reconstructed operand, bit 0 is the MSB
//   err                sticky: an illegal digit (s_x & s_x2) was seen

// Single-digit decode: select lines to a signed 3-bit value in [-2, +2].
module tri_fu_mul_bthacc_dig (
    input  logic       s_neg,
    input  logic       s_x,
    input  logic       s_x2,
    output logic [2:0] d,
    output logic       ill
);
    logic [2:0] mag;

    always_comb begin
        ill = s_x & s_x2;
        mag = {1'b0, s_x2, s_x};
        d   = 3'd0;
        // Illegal encodings contribute nothing; neg with zero magnitude is 0.
        if (!ill)
            d = s_neg ? (3'd0 - mag) : mag;
    end
endmodule

module tri_fu_mul_bthacc #(
    parameter int DIGITS = 27
) (
    input  logic                  nclk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic                  dig_val,
    output logic                  dig_rdy,
    input  logic                  s_neg,
    input  logic                  s_x,
    input  logic                  s_x2,
    output logic                  res_val,
    input  logic                  res_rdy,
    output logic [0:2*DIGITS-1]   res,
    output logic                  err
);
    localparam int WIDTH = 2 * DIGITS;
    localparam int CW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    cnt;
    logic [2:0]       d;
    logic             ill;
    logic             xfer, last;

    tri_fu_mul_bthacc_dig u_dig (
        .s_neg (s_neg),
        .s_x   (s_x),
        .s_x2  (s_x2),
        .d     (d),
        .ill   (ill)
    );

    assign dig_rdy = (state == ACC);
    assign res_val = (state == DONE);
    assign xfer    = dig_val & dig_rdy;
    assign last    = (cnt == CW'(DIGITS - 1));
    // Shift in one radix-4 digit; wraps modulo 2^WIDTH by construction.
    assign acc_nxt = {acc[WIDTH-3:0], 2'b00} + {{(WIDTH-3){d[2]}}, d};

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = ACC;
            ACC:     if (xfer && last) state_nxt = DONE;
            DONE:    if (res_rdy)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
            res <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc <= '0;
                    cnt <= '0;
                    err <= 1'b0;
                end
                ACC: if (xfer) begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (ill) err <= 1'b1;
                    // Capture the final value so res is valid on entry to DONE.
                    if (last) res <= acc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_fu_mul_bthacc.sv
// Directed bench for tri_fu_mul_bthacc with DIGITS=4 (8-bit result).
module tb_tri_fu_mul_bthacc;
    logic       nclk, rst_b, start, dig_val, dig_rdy;
    logic       s_neg, s_x, s_x2, res_val, res_rdy, err;
    logic [0:7] res;
    int         errors = 0;
    int         checks = 0;

    tri_fu_mul_bthacc #(.DIGITS(4)) dut (
        .nclk    (nclk),
        .rst_b   (rst_b),
        .start   (start),
        .dig_val (dig_val),
        .dig_rdy (dig_rdy),
        .s_neg   (s_neg),
        .s_x     (s_x),
        .s_x2    (s_x2),
        .res_val (res_val),
        .res_rdy (res_rdy),
        .res     (res),
        .err     (err)
    );

    initial begin
        nclk = 1'b0;
        forever #5 nclk = ~nclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic n, input logic x, input logic x2);
        int k = 0;
        s_neg = n; s_x = x; s_x2 = x2;
        dig_val = 1'b1;
        while (!dig_rdy && k < 20) begin
            tick();
            k++;
        end
        chk("dig_rdy_wait", {31'd0, dig_rdy}, 32'd1);
        tick();
        dig_val = 1'b0;
    endtask

    task automatic finish_op(input string tag, input logic [7:0] r, input logic e);
        chk({tag, "_val"}, {31'd0, res_val}, 32'd1);
        chk({tag, "_res"}, {24'd0, res}, {24'd0, r});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk({tag, "_idle"}, {31'd0, res_val}, 32'd0);
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b0; dig_val = 1'b0; res_rdy = 1'b0;
        s_neg = 1'b0; s_x = 1'b0; s_x2 = 1'b0;
        #12;
        chk("rst_dig_rdy", {31'd0, dig_rdy}, 32'd0);
        chk("rst_res_val", {31'd0, res_val}, 32'd0);
        chk("rst_res",     {24'd0, res}, 32'd0);
        chk("rst_err",     {31'd0, err}, 32'd0);
        rst_b = 1'b1;
        tick();

        // Round trip 0x5A; a digit offered with start must be ignored.
        s_neg = 1'b0; s_x = 1'b0; s_x2 = 1'b1; dig_val = 1'b1;
        do_start();
        dig_val = 1'b0;
        chk("start_rdy", {31'd0, dig_rdy}, 32'd1);
        send(0, 1, 0); send(0, 0, 1); send(1, 1, 0);
        chk("rt_pre_val", {31'd0, res_val}, 32'd0);
        send(1, 0, 1);
        finish_op("rt", 8'h5A, 1'b0);

        // Negative with negative zero: -2, -0, 0, 0 -> 0x80.
        do_start();
        chk("hold_res", {24'd0, res}, 32'h5A);
        send(1, 0, 1); send(1, 0, 0); send(0, 0, 0); send(0, 0, 0);
        finish_op("neg", 8'h80, 1'b0);

        // Wrap: +2 x4 -> 170.
        do_start();
        send(0, 0, 1); send(0, 0, 1); send(0, 0, 1); send(0, 0, 1);
        finish_op("wrap", 8'hAA, 1'b0);

        // Illegal digit plus backpressure and ignored start in DONE.
        do_start();
        send(0, 1, 0); send(0, 1, 1); send(0, 1, 0); send(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            chk("bp_val", {31'd0, res_val}, 32'd1);
            chk("bp_res", {24'd0, res}, 32'h45);
            chk("bp_err", {31'd0, err}, 32'd1);
            tick();
        end
        start = 1'b1; res_rdy = 1'b1;
        tick();
        start = 1'b0; res_rdy = 1'b0;
        chk("done_start_ign", {31'd0, dig_rdy}, 32'd0);
        chk("done_to_idle",   {31'd0, res_val}, 32'd0);
        chk("err_sticky",     {31'd0, err}, 32'd1);
        do_start();
        chk("err_clear", {31'd0, err}, 32'd0);
        chk("res_kept",  {24'd0, res}, 32'h45);

        // Reset mid-ACC: two digits in, then async reset.
        send(0, 1, 0); send(0, 1, 0);
        #2 rst_b = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'd0, dig_rdy}, 32'd0);
        chk("mid_rst_val", {31'd0, res_val}, 32'd0);
        chk("mid_rst_res", {24'd0, res}, 32'd0);
        tick();
        rst_b = 1'b1;
        tick();
        do_start();
        send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);
        finish_op("post_rst", 8'h55, 1'b0);

        // Bubbles: junk (-2) on invalid cycles must not be taken.
        do_start();
        begin
            logic [6:0] vpat;
            logic [2:0] dt [4];
            int         idx;
            vpat  = 7'b1011001;  // bit i = cycle i: 1,0,0,1,1,0,1
            dt[0] = 3'b010; dt[1] = 3'b110; dt[2] = 3'b010; dt[3] = 3'b000;
            idx = 0;
            for (int c = 0; c < 7; c++) begin
                dig_val = vpat[c];
                if (vpat[c]) begin
                    {s_neg, s_x, s_x2} = dt[idx];
                    idx++;
                end else begin
                    {s_neg, s_x, s_x2} = 3'b101;
                end
                tick();
            end
            dig_val = 1'b0;
        end
        finish_op("bub", 8'h34, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tri_fu_mul_bthacc.md
Name: tri_fu_mul_bthacc

Overview:
Digit-serial Booth re-encoder. It is the inverse of the radix-4 Booth decode used in the FU multiplier. It accepts one Booth digit per handshake as (s_neg, s_x, s_x2), most-significant digit first, and reconstructs the two's-complement operand the digits encode. It sits on the multiplier check/debug path, where it regenerates the operand from the recoded select lines so the result can be compared against the original.

Parameters:
DIGITS, 27, number of radix-4 digits per operand (minimum 2); 27 covers a 53-bit mantissa plus sign extension.
WIDTH, 2*DIGITS, result width in bits (derived; not overridden).

Ports:
nclk      input   1          clock; all state updates on rising edge
rst_b     input   1          asynchronous, active-low reset
start     input   1          begin a new operand; honoured only in IDLE
dig_val   input   1          digit valid
dig_rdy   output  1          digit ready; a transfer occurs when dig_val & dig_rdy
s_neg     input   1          digit sign
s_x       input   1          digit magnitude 1
s_x2      input   1          digit magnitude 2
res_val   output  1          result valid
res_rdy   input   1          result accepted when res_val & res_rdy
res       output  [0:WIDTH-1] reconstructed operand, bit 0 = MSB, two's complement
err       output  1          illegal digit seen in the current operand

Behaviour:
- Reset (rst_b=0, asynchronous): state=IDLE; acc=0; cnt=0; err=0; dig_rdy=0; res_val=0; res=0.
- Digit value d:
  - (0,0,0)=0, (0,1,0)=+1, (0,0,1)=+2, (1,1,0)=-1, (1,0,1)=-2, (1,0,0)=0 (negative zero).
  - s_x & s_x2 both 1 is illegal: the digit is treated as 0 and err is set; err stays set (sticky) until the next start.
- States:
  - IDLE: dig_rdy=0, res_val=0. start=1 gives ACC next cycle, with acc=0, cnt=0, err=0. A digit cannot be accepted in the same cycle as start.
  - ACC: dig_rdy=1. On each transfer, acc <= acc*4 + sext(d), computed modulo 2^WIDTH (wraps with no overflow flag), and cnt <= cnt+1. When the transfer with cnt==DIGITS-1 occurs, the next state is DONE. A cycle with no transfer holds all state. start is ignored.
  - DONE: res_val=1, dig_rdy=0, res=acc, err valid. Outputs hold until res_rdy=1, then the next state is IDLE. start in DONE is ignored, including the cycle that res_rdy is accepted.
- Latency: res_val asserts exactly 1 cycle after the final digit transfer. Minimum operand time is 1 (start) + DIGITS + 1 cycles.
- res is a registered copy of acc. In IDLE and ACC, res holds its last value and is not valid. err is registered.
- Reset mid-operation discards the partial accumulation immediately and forces the outputs to their reset values.
- cnt width is clog2(DIGITS). No wrap is possible because DONE is reached at DIGITS-1.

Test Plan:
- Reset mid-ACC: with DIGITS=4, start, send 2 digits, assert rst_b=0 -> dig_rdy=0, res_val=0, res=0 asynchronously. After release, a new start plus 4 digits of (0,1,0) -> res=0x55.
- Round trip: DIGITS=4, start, then digits MSB-first +1,+2,-1,-2 (the Booth decode of 0x5A) -> res=0x5A, err=0, res_val exactly 1 cycle after the 4th transfer.
- Negative and neg-zero: digits -2,(1,0,0),0,0 -> res=0x80, err=0.
- Wrap: digits +2,+2,+2,+2 -> res=0xAA (170 mod 256), err=0.
- Illegal and backpressure:
  - Digits +1,(0,1,1),+1,+1 -> res=0x45, err=1.
  - Hold res_rdy=0 for 5 cycles -> res, err and res_val stable.
  - A start pulsed during DONE is ignored. After res_rdy, state is IDLE and err clears on the next start.
- Bubbles: dig_val toggled 1,0,0,1,1,0,1 carrying +1,-1,+1,0 -> exactly 4 transfers, res=0x34, no digit lost or duplicated.
